hex_decoder: RTL and testbench

Registered dual-digit 7-segment decoder for the physical score display. It takes two 4-bit digit codes (ones and tens) from the score counter and drives two active-low 7-segment displays (HEX4 = ones, HEX5 = tens). It supports decimal and hexadecimal glyph sets, forced blanking and optional leading-zero suppression. Outputs are registered so segment lines never glitch.

---
 rtl/hex_decoder.sv | 98 +++++++++
 tb/tb_hex_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hex_decoder.sv
// Registered dual-digit 7-segment decoder for the score display (HEX4 = ones, HEX5 = tens).
// Segment outputs are active-low {g,f,e,d,c,b,a} and are registered so they never glitch.
module hex_decoder #(
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_hex,
  input  logic [3:0] i_hex1,
  input  logic       i_hex_mode,
  input  logic       i_blank,
  output logic [6:0] o_display,
  output logic [6:0] o_display1,
  output logic       o_valid
);

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [3:0] r_d0;
  logic [3:0] r_d1;
  logic [6:0] r_display;
  logic [6:0] r_display1;
  logic       r_valid;
  logic [6:0] w_glyph0;
  logic [6:0] w_glyph1;
  logic [6:0] w_next_display;
  logic [6:0] w_next_display1;

  // Letters only appear in hex mode; otherwise codes 10-15 show nothing.
  function automatic logic [6:0] f_seg(input logic [3:0] code, input logic hex_mode);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b0001000;
      4'd11:   seg = 7'b0000011;
      4'd12:   seg = 7'b1000110;
      4'd13:   seg = 7'b0100001;
      4'd14:   seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    if ((code > 4'd9) && !hex_mode) begin
      seg = SEG_OFF;
    end
    return seg;
  endfunction

  assign w_glyph0 = f_seg(r_d0, i_hex_mode);
  assign w_glyph1 = f_seg(r_d1, i_hex_mode);

  always_comb begin
    w_next_display  = w_glyph0;
    w_next_display1 = w_glyph1;
    if (i_blank) begin
      w_next_display  = SEG_OFF;
      w_next_display1 = SEG_OFF;
    end else if (LZ_BLANK && (r_d1 == 4'd0)) begin
      w_next_display1 = SEG_OFF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d0 <= 4'd0;
      r_d1 <= 4'd0;
    end else if (i_load) begin
      r_d0 <= i_hex;
      r_d1 <= i_hex1;
    end
  end

  // Output stage reads the digit registers, giving two edges from load to segments.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_display  <= SEG_OFF;
      r_display1 <= SEG_OFF;
      r_valid    <= 1'b0;
    end else begin
      r_display  <= w_next_display;
      r_display1 <= w_next_display1;
      r_valid    <= (r_d0 <= 4'd9) && (r_d1 <= 4'd9);
    end
  end

  assign o_display  = r_display;
  assign o_display1 = r_display1;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_hex_decoder.sv
// Self-checking bench for hex_decoder: a glyph-table model checked every cycle,
// plus literal expectations, on two instances (leading-zero blanking off and on).
module tb_hex_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] hex = 4'd0;
  logic [3:0] hex1 = 4'd0;
  logic       hexMode = 1'b0;
  logic       blank = 1'b0;

  logic [6:0] disp0, disp1;
  logic       valid0;
  logic [6:0] dispLz0, dispLz1;
  logic       validLz;

  int checks = 0;
  int failures = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  hex_decoder #(.LZ_BLANK(1'b0)) dutPlain (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_hex(hex), .i_hex1(hex1),
    .i_hex_mode(hexMode), .i_blank(blank),
    .o_display(disp0), .o_display1(disp1), .o_valid(valid0)
  );

  hex_decoder #(.LZ_BLANK(1'b1)) dutLz (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_hex(hex), .i_hex1(hex1),
    .i_hex_mode(hexMode), .i_blank(blank),
    .o_display(dispLz0), .o_display1(dispLz1), .o_valid(validLz)
  );

  // Reference glyphs indexed by digit code
  logic [6:0] glyphs [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] OFF = 7'b1111111;

  function automatic logic [6:0] shown(input int code, input logic mode, input logic blk);
    if (blk) return OFF;
    if (code > 9 && !mode) return OFF;
    return glyphs[code];
  endfunction

  // Model: the digits latched so far, and what each display must show after this edge
  int         mOnes, mTens;
  logic [6:0] expD0, expD1, expLz1;
  logic       expValid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOnes    <= 0;
      mTens    <= 0;
      expD0    <= OFF;
      expD1    <= OFF;
      expLz1   <= OFF;
      expValid <= 1'b0;
    end else begin
      expD0    <= shown(mOnes, hexMode, blank);
      expD1    <= shown(mTens, hexMode, blank);
      expLz1   <= (mTens == 0) ? OFF : shown(mTens, hexMode, blank);
      expValid <= (mOnes < 10) && (mTens < 10);
      if (load) begin
        mOnes <= int'(hex);
        mTens <= int'(hex1);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model display",      disp0,           expD0);
      checkOutput("model display1",     disp1,           expD1);
      checkOutput("model valid",        {6'd0, valid0},  {6'd0, expValid});
      checkOutput("model lz display",   dispLz0,         expD0);
      checkOutput("model lz display1",  dispLz1,         expLz1);
      checkOutput("model lz valid",     {6'd0, validLz}, {6'd0, expValid});
    end
  end

  task automatic applyStimulus(input logic ld, input int h0, input int h1,
                               input logic mode, input logic blk);
    load    = ld;
    hex     = 4'(h0);
    hex1    = 4'(h1);
    hexMode = mode;
    blank   = blk;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset display",  disp0, OFF);
    checkOutput("reset display1", disp1, OFF);
    checkOutput("reset valid",    {6'd0, valid0}, 7'd0);
    checkEn = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release display",     disp0,   7'b1000000);
    checkOutput("release display1",    disp1,   7'b1000000);
    checkOutput("release valid",       {6'd0, valid0}, 7'd1);
    checkOutput("release lz display1", dispLz1, OFF);

    applyStimulus(1, 7, 4, 0, 0);
    applyStimulus(0, 9, 9, 0, 0);
    checkOutput("74 display",  disp0, 7'b1111000);
    checkOutput("74 display1", disp1, 7'b0011001);
    applyStimulus(0, 3, 3, 0, 0);
    checkOutput("74 hold", disp0, 7'b1111000);

    applyStimulus(1, 12, 15, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("hexC display",  disp0, 7'b1000110);
    checkOutput("hexF display1", disp1, 7'b0001110);
    checkOutput("hex valid",     {6'd0, valid0}, 7'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("decimal blanks C", disp0, OFF);
    checkOutput("decimal blanks F", disp1, OFF);

    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lz ones 5",      dispLz0, 7'b0010010);
    checkOutput("lz tens blank",  dispLz1, OFF);
    checkOutput("plain tens 0",   disp1,   7'b1000000);
    applyStimulus(1, 5, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lz tens 3", dispLz1, 7'b0110000);

    applyStimulus(1, 2, 4, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("blank display",  disp0, OFF);
    checkOutput("blank display1", disp1, OFF);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("unblank 2", disp0, 7'b0100100);
    checkOutput("unblank 4", disp1, 7'b0011001);

    applyStimulus(1, 8, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("load under blank 8", disp0, 7'b0000000);
    checkOutput("load under blank 1", disp1, 7'b1111001);

    for (int i = 0; i < 16; i++) applyStimulus(1, i, 15 - i, 1'(i % 2), 0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom_range(1)), $urandom_range(15), $urandom_range(15),
                    1'($urandom_range(1)), 1'($urandom_range(3) == 0));

    applyStimulus(1, 9, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("99 display", disp0, 7'b0010000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset display",  disp0, OFF);
    checkOutput("async reset display1", disp1, OFF);
    checkOutput("async reset valid",    {6'd0, valid0}, 7'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after reset display",  disp0, 7'b1000000);
    checkOutput("after reset display1", disp1, 7'b1000000);
    checkOutput("after reset valid",    {6'd0, valid0}, 7'd1);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
